// File: rtl/microcode_store_if.sv
// Read/program bus for the microcode store.
// Three synchronous read ports share en; one write port serves all tables.
interface microcode_store_if #(
  parameter int DEC_AW  = 4,
  parameter int CTRL_AW = 8
);
  logic               en;
  logic [DEC_AW-1:0]  dec_addr;
  logic [7:0]         dec_data;
  logic [CTRL_AW-1:0] ctrl_addr;
  logic [15:0]        ctrl_a_data;
  logic [15:0]        ctrl_b_data;
  logic               wr_en;
  logic [1:0]         wr_sel;
  logic [CTRL_AW-1:0] wr_addr;
  logic [15:0]        wr_data;

  modport master (
    output en, dec_addr, ctrl_addr,
    output wr_en, wr_sel, wr_addr, wr_data,
    input  dec_data, ctrl_a_data, ctrl_b_data
  );

  modport slave (
    input  en, dec_addr, ctrl_addr,
    input  wr_en, wr_sel, wr_addr, wr_data,
    output dec_data, ctrl_a_data, ctrl_b_data
  );
endinterface

// File: rtl/microcode_store.sv
// Decode table plus two control tables with registered, read-first outputs.
// Reset clears every word, so tables are built from resettable flops.
module microcode_store #(
  parameter int DEC_AW  = 4,
  parameter int CTRL_AW = 8
) (
  input  logic clk,
  input  logic rst,
  microcode_store_if.slave bus
);
  localparam int DEC_N  = 1 << DEC_AW;
  localparam int CTRL_N = 1 << CTRL_AW;

  logic [7:0]  dec_mem [DEC_N];
  logic [15:0] a_mem   [CTRL_N];
  logic [15:0] b_mem   [CTRL_N];

  logic [7:0]  dec_q;
  logic [15:0] a_q;
  logic [15:0] b_q;

  logic wr_dec;
  logic wr_a;
  logic wr_b;

  always_comb begin
    wr_dec = 1'b0;
    wr_a   = 1'b0;
    wr_b   = 1'b0;
    if (bus.wr_en) begin
      unique case (1'b1)
        (bus.wr_sel == 2'b00): wr_dec = 1'b1;
        (bus.wr_sel == 2'b01): wr_a   = 1'b1;
        (bus.wr_sel == 2'b10): wr_b   = 1'b1;
        (bus.wr_sel == 2'b11): ;
        default: ;
      endcase
    end
  end

  // Reads sample the old word; writes land via NBA after the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      for (int i = 0; i < DEC_N; i++)
        dec_mem[i] <= '0;
      for (int i = 0; i < CTRL_N; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else begin
      if (bus.en) begin
        dec_q <= dec_mem[bus.dec_addr];
        a_q   <= a_mem[bus.ctrl_addr];
        b_q   <= b_mem[bus.ctrl_addr];
      end else begin
        dec_q <= '0;
        a_q   <= '0;
        b_q   <= '0;
      end
      if (wr_dec)
        dec_mem[bus.wr_addr[DEC_AW-1:0]] <= bus.wr_data[7:0];
      if (wr_a)
        a_mem[bus.wr_addr] <= bus.wr_data;
      if (wr_b)
        b_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.dec_data    = dec_q;
  assign bus.ctrl_a_data = a_q;
  assign bus.ctrl_b_data = b_q;
endmodule

// File: tb/tb_microcode_store.sv
// Bench for microcode_store: directed cases plus random traffic
// checked against an array-based model of the three tables.
module tb_microcode_store;
  logic clk = 1'b0;
  logic rst = 1'b0;

  microcode_store_if #(.DEC_AW(4), .CTRL_AW(8)) bus ();

  microcode_store #(.DEC_AW(4), .CTRL_AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  dec_m [16];
  logic [15:0] a_m   [256];
  logic [15:0] b_m   [256];

  task automatic check(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  task automatic cyc(
    input logic        r,
    input logic        e,
    input logic [3:0]  da,
    input logic [7:0]  ca,
    input logic        we,
    input logic [1:0]  ws,
    input logic [7:0]  wa,
    input logic [15:0] wd
  );
    logic [7:0]  ed;
    logic [15:0] ea;
    logic [15:0] eb;
    rst           = r;
    bus.en        = e;
    bus.dec_addr  = da;
    bus.ctrl_addr = ca;
    bus.wr_en     = we;
    bus.wr_sel    = ws;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    ed = 8'h00;
    ea = 16'h0000;
    eb = 16'h0000;
    if (r) begin
      for (int i = 0; i < 16; i++)
        dec_m[i] = 8'h00;
      for (int i = 0; i < 256; i++) begin
        a_m[i] = 16'h0000;
        b_m[i] = 16'h0000;
      end
    end else begin
      if (e) begin
        ed = dec_m[da];
        ea = a_m[ca];
        eb = b_m[ca];
      end
      if (we) begin
        if (ws == 2'b00) dec_m[wa[3:0]] = wd[7:0];
        if (ws == 2'b01) a_m[wa] = wd;
        if (ws == 2'b10) b_m[wa] = wd;
      end
    end
    @(posedge clk);
    #1;
    check("dec", {8'h00, bus.dec_data}, {8'h00, ed});
    check("ctl_a", bus.ctrl_a_data, ea);
    check("ctl_b", bus.ctrl_b_data, eb);
  endtask

  task automatic wr(
    input logic [1:0]  ws,
    input logic [7:0]  wa,
    input logic [15:0] wd
  );
    cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, ws, wa, wd);
  endtask

  task automatic rd(
    input logic [3:0] da,
    input logic [7:0] ca
  );
    cyc(1'b0, 1'b1, da, ca, 1'b0, 2'b11, 8'h00, 16'h0);
  endtask

  initial begin
    logic [7:0] ra;
    rst         = 1'b0;
    bus.en      = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 2'b11;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.dec_addr  = '0;
    bus.ctrl_addr = '0;
    @(negedge clk);

    // reset then read
    cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 2'b11, 8'h00, 16'h0);
    rd(4'h0, 8'h00);
    check("rst_rd_a", bus.ctrl_a_data, 16'h0000);
    check("rst_rd_dec", {8'h00, bus.dec_data}, 16'h0000);

    // write and read all three tables
    wr(2'b01, 8'h12, 16'hBEEF);
    wr(2'b10, 8'h12, 16'h0C3A);
    wr(2'b00, 8'h05, 16'h0040);
    rd(4'h5, 8'h12);
    check("wr_rd_a", bus.ctrl_a_data, 16'hBEEF);
    check("wr_rd_b", bus.ctrl_b_data, 16'h0C3A);
    check("wr_rd_dec", {8'h00, bus.dec_data}, 16'h0040);

    // chip select
    cyc(1'b0, 1'b0, 4'h5, 8'h12, 1'b0, 2'b11, 8'h00, 16'h0);
    check("cs_off_a", bus.ctrl_a_data, 16'h0000);
    rd(4'h5, 8'h12);
    check("cs_on_a", bus.ctrl_a_data, 16'hBEEF);

    // read-first at top address, decode aliasing
    wr(2'b01, 8'hFF, 16'h1111);
    cyc(1'b0, 1'b1, 4'hF, 8'hFF, 1'b1, 2'b01, 8'hFF, 16'h2222);
    check("rf_old", bus.ctrl_a_data, 16'h1111);
    rd(4'hF, 8'hFF);
    check("rf_new", bus.ctrl_a_data, 16'h2222);
    wr(2'b00, 8'h37, 16'h12A5);
    rd(4'h7, 8'h00);
    check("dec_alias", {8'h00, bus.dec_data}, 16'h00A5);

    // reset priority over write, contents discarded
    cyc(1'b1, 1'b1, 4'h0, 8'h01, 1'b1, 2'b01, 8'h01, 16'hFFFF);
    check("rst_out", bus.ctrl_a_data, 16'h0000);
    rd(4'h5, 8'h01);
    check("rst_prio", bus.ctrl_a_data, 16'h0000);
    rd(4'h5, 8'h12);
    check("rst_clr_a", bus.ctrl_a_data, 16'h0000);
    check("rst_clr_dec", {8'h00, bus.dec_data}, 16'h0000);

    // wr_sel=11 ignored, B write leaves A alone
    wr(2'b01, 8'h20, 16'h1234);
    wr(2'b11, 8'h20, 16'h5555);
    rd(4'h0, 8'h20);
    check("sel11_a", bus.ctrl_a_data, 16'h1234);
    check("sel11_b", bus.ctrl_b_data, 16'h0000);
    check("sel11_dec", {8'h00, bus.dec_data}, 16'h0000);
    wr(2'b10, 8'h20, 16'h9999);
    rd(4'h0, 8'h20);
    check("iso_a", bus.ctrl_a_data, 16'h1234);
    check("iso_b", bus.ctrl_b_data, 16'h9999);

    // random traffic over a narrow address pool to force hits
    for (int n = 0; n < 3000; n++) begin
      ra = 8'($urandom_range(0, 7));
      if (ra > 8'd3) ra = ra + 8'hF8;
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 3) != 0),
          4'($urandom_range(0, 15)),
          ($urandom_range(0, 1) != 0) ? ra : 8'($urandom),
          ($urandom_range(0, 1) != 0),
          2'($urandom),
          ($urandom_range(0, 1) != 0) ? ra : 8'($urandom),
          16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
